// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard controller.
//   FWD_*      : Execute-operand forwarding select values.
//   md_state_e : state encoding of the mult/div busy tracker.
//   fwd_sel()  : resolves one Execute operand's forwarding source.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUOutM

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // M stage wins over W since it holds the younger result; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wreg_m, input logic we_m,
                                         input logic [4:0] wreg_w, input logic we_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && src == wreg_m && we_m) begin
      sel = FWD_M;
    end else if (src != 5'd0 && src == wreg_w && we_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_busy.sv
// muldiv_busy: tracks occupancy of the HI/LO unit after a mult/div issues.
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts any operation in flight)
//   start : mult/div entering Execute; ignored while already busy
//   div   : qualifies start, 1 = divide (DIV_CYCLES), 0 = multiply (MUL_CYCLES)
//   busy  : registered, high for exactly the operation's cycle count
module muldiv_busy
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES) + 1;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loading N-1 and exiting on zero yields exactly N busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = div ? CntW'(DIV_CYCLES - 1) : CntW'(MUL_CYCLES - 1);
        end
      end
      BUSY: begin
        // A start seen here is a protocol violation and is dropped.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding and stall control for a 5-stage MIPS-style pipeline.
// Inputs : register numbers/write enables of D, E, M, W; load flags (E, M); BranchD;
//          mult/div issue info (MulDivD, MulDivStartE, DivE) and HiLoReadD.
// Outputs: StallF/StallD/FlushE (load-use, branch and HI/LO stalls), ForwardAD/BD
//          (branch comparator), ForwardAE/BE (Execute operand select), MulDivBusy.
// Build option: define HAZARD_MULDIV_EN to include the HI/LO busy tracker and its
// stall; otherwise MulDivBusy is 0 and the mult/div inputs are ignored.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MulDivD,
  input  logic       MulDivStartE,
  input  logic       DivE,
  input  logic       HiLoReadD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDivBusy
);

  logic lwstall, branchstall, mdstall, stall;

  assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);

  assign ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

  assign lwstall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));

  // Branch operands are needed in D: an ALU result still in E, or a load still in M,
  // cannot be forwarded in time.
  assign branchstall = BranchD &&
                       ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

`ifdef HAZARD_MULDIV_EN
  muldiv_busy #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_muldiv_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .start (MulDivStartE),
    .div   (DivE),
    .busy  (MulDivBusy)
  );

  assign mdstall = MulDivBusy && (HiLoReadD || MulDivD);
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{clk, rst_n, MulDivD, MulDivStartE, DivE, HiLoReadD,
                           1'(MUL_CYCLES), 1'(DIV_CYCLES)};
  assign MulDivBusy = 1'b0;
  assign mdstall    = 1'b0;
`endif

  assign stall  = lwstall || branchstall || mdstall;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: number of cycles a multiply occupies HI/LO.
REQ-002 Parameter DIV_CYCLES, default 32: number of cycles a divide occupies HI/LO.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 RsD, RtD  in  5 each  source register numbers of the instruction in Decode.
REQ-006 RsE, RtE  in  5 each  source register numbers of the instruction in Execute.
REQ-007 WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register numbers in E, M and W.
REQ-008 RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables in E, M and W.
REQ-009 MemtoRegE, MemtoRegM  in  1 each  load-instruction flags in E and M.
REQ-010 BranchD  in  1  branch resolved in Decode.
REQ-011 MulDivD  in  1  mult/div instruction in Decode.
REQ-012 MulDivStartE  in  1  mult/div instruction entering Execute this cycle.
REQ-013 DivE  in  1  qualifies MulDivStartE: 1 = divide, 0 = multiply.
REQ-014 HiLoReadD  in  1  mfhi/mflo instruction in Decode.
REQ-015 StallF, StallD  out  1 each  hold the PC register and the F/D pipeline register.
REQ-016 FlushE  out  1  clear the D/E pipeline register (inject bubble).
REQ-017 ForwardAD, ForwardBD  out  1 each  forward ALUOutM to the Decode branch comparator.
REQ-018 ForwardAE, ForwardBE  out  2 each  Execute operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-019 MulDivBusy  out  1  HI/LO unit occupied.

Function
REQ-020 ForwardAE SHALL be 10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if RsE!=0 && RsE==WriteRegW && RegWriteW; else 00; ForwardBE likewise with RtE (the M stage has priority).
REQ-021 ForwardAD SHALL equal (RsD!=0 && RsD==WriteRegM && RegWriteM); ForwardBD likewise with RtD.
REQ-022 lwstall SHALL equal MemtoRegE && (RtE==RsD || RtE==RtD).
REQ-023 branchstall SHALL equal BranchD && ((RegWriteE && (WriteRegE==RsD || WriteRegE==RtD)) || (MemtoRegM && (WriteRegM==RsD || WriteRegM==RtD))).
REQ-024 mdstall SHALL equal MulDivBusy && (HiLoReadD || MulDivD).
REQ-025 StallF = StallD = FlushE SHALL equal lwstall || branchstall || mdstall; all forwarding and stall outputs are combinational (zero latency).
REQ-026 The FSM SHALL have states IDLE and BUSY, with a down-counter cnt of width clog2(DIV_CYCLES)+1.
REQ-027 IDLE -> BUSY on MulDivStartE; cnt loads DIV_CYCLES-1 if DivE, else MUL_CYCLES-1.
REQ-028 BUSY: cnt decrements each cycle; BUSY -> IDLE on the cycle cnt==0.
REQ-029 MulDivBusy SHALL be 1 exactly when the state is BUSY (registered output).
REQ-030 MulDivStartE while BUSY (this can only occur through a protocol violation) SHALL be ignored; cnt is not reloaded.
REQ-031 If MulDivStartE and cnt==0 occur in the same BUSY cycle, the state SHALL go to IDLE and the start SHALL be ignored.

Reset
REQ-032 While rst_n is low: the state SHALL be IDLE, cnt 0 and MulDivBusy 0, taking effect immediately without waiting for clk.
REQ-033 Asserting reset mid-BUSY SHALL abort the operation; after release, the first MulDivStartE starts a fresh count.

Configuration
REQ-034 Macro HAZARD_MULDIV_EN defined: REQ-024 and REQ-026 to REQ-031 are present.
REQ-035 Macro HAZARD_MULDIV_EN undefined: no FSM or counter is built, MulDivBusy is tied to 0, mdstall is 0, and the MulDiv*/DivE/HiLoReadD inputs are unused.

Structure
REQ-036 A shared package hazard_pkg SHALL hold the forwarding select encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10 and the state encoding IDLE/BUSY.
REQ-037 The mult/div busy FSM plus counter SHALL be one sub-module, muldiv_busy (clk, rst_n, start, div, busy).

Verification
REQ-038 Set RsE=8, WriteRegM=8, RegWriteM=1, WriteRegW=8, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01; with RsE=0 -> 00.
REQ-039 Set MemtoRegE=1, RtE=9, RsD=9 -> StallF=StallD=FlushE=1 in the same cycle; with RsD=RtD=10 -> all 0.
REQ-040 Set BranchD=1, RegWriteE=1, WriteRegE=RtD=4 -> stall=1; with the same register in M (MemtoRegM=1) -> stall=1; with it in M and RegWriteM=1 only -> stall=0, ForwardBD=1.
REQ-041 Pulse MulDivStartE with DivE=0, hold HiLoReadD=1 -> MulDivBusy=1 for exactly 4 cycles and stall for those 4 cycles, then 0; with DivE=1 -> 32 cycles.
REQ-042 Drop rst_n at cycle 10 of a divide -> MulDivBusy=0 with no clock edge; after release, MulDivStartE with DivE=0 -> busy for 4 cycles.
REQ-043 Build without HAZARD_MULDIV_EN and pulse MulDivStartE with HiLoReadD=1 -> MulDivBusy=0 and no stall.
